dmem_ddr_bridge: RTL and testbench

DMEM_DDR_BRIDGE -- requirements
Module: dmem_ddr_bridge

---
 rtl/dmem_ddr_bridge.sv | 179 +++++++++++++++++
 tb/tb_dmem_ddr_bridge.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ddr_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_ddr_bridge : stalls the memory stage and turns one load/store into a
//                   DDR controller app_* transaction.  Rev 1.0
// ---------------------------------------------------------------------------
module dmem_ddr_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 28,
  parameter int TIMEOUT    = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_req_valid,
  input  logic                  i_req_we,
  input  logic [31:0]           i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [3:0]            i_req_be,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_err,
  output logic                  o_app_en,
  output logic [2:0]            o_app_cmd,
  output logic [ADDR_WIDTH-1:0] o_app_addr,
  input  logic                  i_app_rdy,
  output logic                  o_app_wdf_wren,
  output logic                  o_app_wdf_end,
  output logic [DATA_WIDTH-1:0] o_app_wdf_data,
  output logic [3:0]            o_app_wdf_mask,
  input  logic                  i_app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0] i_app_rd_data,
  input  logic                  i_app_rd_data_valid
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_CMD  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [2:0] c_CMD_WRITE = 3'b000;
  localparam logic [2:0] c_CMD_READ  = 3'b001;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]              mask_q, mask_d;
  logic                    cmd_done_q, cmd_done_d;
  logic                    data_done_q, data_done_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    is_rd_q, is_rd_d;
  logic                    timeout_q, timeout_d;

  logic                    w_app_en;
  logic [2:0]              w_app_cmd;
  logic                    w_wdf_wren;
  logic                    w_stall;
  logic [7:0]              w_cnt_inc;

  // Address bits outside the word-aligned controller window are dropped.
  logic w_unused;
  assign w_unused  = ^{i_req_addr[31:ADDR_WIDTH], i_req_addr[1:0]};
  assign w_cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    cnt_d       = cnt_q;
    rd_data_d   = rd_data_q;
    is_rd_d     = is_rd_q;
    timeout_d   = timeout_q;
    w_app_en    = 1'b0;
    w_app_cmd   = c_CMD_WRITE;
    w_wdf_wren  = 1'b0;
    w_stall     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          w_stall     = 1'b1;
          addr_d      = {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d     = i_req_wdata;
          mask_d      = ~i_req_be;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
          is_rd_d     = ~i_req_we;
          timeout_d   = 1'b0;
          state_d     = i_req_we ? S_WR : S_RD_CMD;
        end
      end
      S_WR: begin
        // Command and write data are accepted independently, in any order.
        w_stall    = 1'b1;
        w_app_en   = ~cmd_done_q;
        w_wdf_wren = ~data_done_q;
        if (i_app_rdy)     cmd_done_d  = 1'b1;
        if (i_app_wdf_rdy) data_done_d = 1'b1;
        if ((cmd_done_q || i_app_rdy) && (data_done_q || i_app_wdf_rdy))
          state_d = S_DONE;
      end
      S_RD_CMD: begin
        w_stall   = 1'b1;
        w_app_en  = 1'b1;
        w_app_cmd = c_CMD_READ;
        if (i_app_rdy) begin
          cnt_d   = 8'd0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // Abort on the TIMEOUT-th wait cycle unless data shows up in it.
        w_stall = 1'b1;
        cnt_d   = w_cnt_inc;
        if (i_app_rd_data_valid) begin
          rd_data_d = i_app_rd_data;
          state_d   = S_DONE;
        end else if (w_cnt_inc == 8'(TIMEOUT)) begin
          rd_data_d = DATA_WIDTH'(32'hDEADBEEF);
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      cnt_q       <= 8'd0;
      rd_data_q   <= '0;
      is_rd_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
      cnt_q       <= cnt_d;
      rd_data_q   <= rd_data_d;
      is_rd_q     <= is_rd_d;
      timeout_q   <= timeout_d;
    end
  end

  // Strobes are forced low for the whole reset window, not just after the edge.
  assign o_stall        = w_stall & i_reset_n;
  assign o_app_en       = w_app_en & i_reset_n;
  assign o_app_cmd      = w_app_cmd;
  assign o_app_addr     = addr_q;
  assign o_app_wdf_wren = w_wdf_wren & i_reset_n;
  assign o_app_wdf_end  = o_app_wdf_wren;
  assign o_app_wdf_data = wdata_q;
  assign o_app_wdf_mask = mask_q;
  assign o_rd_data      = rd_data_q;
  assign o_rd_valid     = (state_q == S_DONE) & is_rd_q & i_reset_n;
  assign o_err          = (state_q == S_DONE) & timeout_q & i_reset_n;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ddr_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_ddr_bridge : directed self-checking bench for dmem_ddr_bridge.
//                      Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_ddr_bridge;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_req_valid, i_req_we;
  logic [31:0] i_req_addr, i_req_wdata;
  logic [3:0]  i_req_be;
  logic        o_stall, o_rd_valid, o_err, o_app_en;
  logic [31:0] o_rd_data;
  logic [2:0]  o_app_cmd;
  logic [27:0] o_app_addr;
  logic        i_app_rdy, o_app_wdf_wren, o_app_wdf_end, i_app_wdf_rdy;
  logic [31:0] o_app_wdf_data, i_app_rd_data;
  logic [3:0]  o_app_wdf_mask;
  logic        i_app_rd_data_valid;

  int n_total = 0;
  int n_bad   = 0;
  int n_cmd   = 0;
  int cmd_base;

  always #5 i_clk = ~i_clk;

  dmem_ddr_bridge dut (
    .i_clk               (i_clk),
    .i_reset_n           (i_reset_n),
    .i_req_valid         (i_req_valid),
    .i_req_we            (i_req_we),
    .i_req_addr          (i_req_addr),
    .i_req_wdata         (i_req_wdata),
    .i_req_be            (i_req_be),
    .o_stall             (o_stall),
    .o_rd_data           (o_rd_data),
    .o_rd_valid          (o_rd_valid),
    .o_err               (o_err),
    .o_app_en            (o_app_en),
    .o_app_cmd           (o_app_cmd),
    .o_app_addr          (o_app_addr),
    .i_app_rdy           (i_app_rdy),
    .o_app_wdf_wren      (o_app_wdf_wren),
    .o_app_wdf_end       (o_app_wdf_end),
    .o_app_wdf_data      (o_app_wdf_data),
    .o_app_wdf_mask      (o_app_wdf_mask),
    .i_app_wdf_rdy       (i_app_wdf_rdy),
    .i_app_rd_data       (i_app_rd_data),
    .i_app_rd_data_valid (i_app_rd_data_valid)
  );

  // Counts controller commands actually handed over.
  always @(posedge i_clk) if (o_app_en && i_app_rdy) n_cmd <= n_cmd + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Advance to the next falling edge; inputs are changed there, outputs read 1ns later.
  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_wdata = wd;
    i_req_be    = be;
  endtask

  initial begin
    i_reset_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0;
    i_req_wdata = '0; i_req_be = '0; i_app_rdy = 1'b0; i_app_wdf_rdy = 1'b0;
    i_app_rd_data = '0; i_app_rd_data_valid = 1'b0;
    @(negedge i_clk);
    step();
    #1;
    check("rst_app_en", o_app_en, 0);
    check("rst_wren", o_app_wdf_wren, 0);
    check("rst_wend", o_app_wdf_end, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check("rst_err", o_err, 0);
    check("rst_rd_data", o_rd_data, 0);
    check("rst_stall", o_stall, 0);
    step();
    i_reset_n = 1'b1;

    // Store, both readys high
    req(1'b1, 32'h0000_0104, 32'hA5A5_5A5A, 4'b0011);
    i_app_rdy = 1'b1; i_app_wdf_rdy = 1'b1;
    #1;
    check("st_idle_stall", o_stall, 1);
    check("st_idle_en", o_app_en, 0);
    step(); #1;
    check("st_wr_en", o_app_en, 1);
    check("st_wr_wren", o_app_wdf_wren, 1);
    check("st_wr_wend", o_app_wdf_end, 1);
    check("st_wr_cmd", o_app_cmd, 3'b000);
    check("st_wr_addr", o_app_addr, 28'h104);
    check("st_wr_mask", o_app_wdf_mask, 4'b1100);
    check("st_wr_data", o_app_wdf_data, 32'hA5A5_5A5A);
    check("st_wr_stall", o_stall, 1);
    step(); #1;
    check("st_done_stall", o_stall, 0);
    check("st_done_rdv", o_rd_valid, 0);
    check("st_done_en", o_app_en, 0);
    check("st_done_wren", o_app_wdf_wren, 0);
    step();
    i_req_valid = 1'b0; #1;
    check("st_idle2_stall", o_stall, 0);
    check("st_idle2_en", o_app_en, 0);

    // Store, command accepted at once, write data late
    step();
    req(1'b1, 32'h0000_0208, 32'h0BAD_F00D, 4'b1111);
    i_app_rdy = 1'b1; i_app_wdf_rdy = 1'b0;
    step(); #1;
    check("sd_c1_en", o_app_en, 1);
    check("sd_c1_wren", o_app_wdf_wren, 1);
    check("sd_c1_mask", o_app_wdf_mask, 4'b0000);
    step();
    i_app_rdy = 1'b0; #1;
    check("sd_c2_en", o_app_en, 0);
    check("sd_c2_wren", o_app_wdf_wren, 1);
    check("sd_c2_stall", o_stall, 1);
    step(); #1;
    check("sd_c3_wren", o_app_wdf_wren, 1);
    step();
    i_app_wdf_rdy = 1'b1; #1;
    check("sd_c4_wren", o_app_wdf_wren, 1);
    check("sd_c4_stall", o_stall, 1);
    step(); #1;
    check("sd_done_stall", o_stall, 0);
    check("sd_done_wren", o_app_wdf_wren, 0);
    check("sd_done_rdv", o_rd_valid, 0);
    step();
    i_req_valid = 1'b0; i_app_wdf_rdy = 1'b0;

    // Load, command accepted after 2 cycles, data 3 cycles after accept
    step();
    req(1'b0, 32'h0000_0203, 32'h0, 4'b0000);
    i_app_rdy = 1'b0;
    step(); #1;
    check("ld_c1_en", o_app_en, 1);
    check("ld_c1_cmd", o_app_cmd, 3'b001);
    check("ld_c1_addr", o_app_addr, 28'h200);
    check("ld_c1_wren", o_app_wdf_wren, 0);
    step();
    i_app_rdy = 1'b1; #1;
    check("ld_c2_en", o_app_en, 1);
    step();
    i_app_rdy = 1'b0; #1;
    check("ld_wait_en", o_app_en, 0);
    check("ld_wait_stall", o_stall, 1);
    step();
    step();
    i_app_rd_data = 32'h1234_5678; i_app_rd_data_valid = 1'b1; #1;
    check("ld_c5_rdv", o_rd_valid, 0);
    step();
    i_app_rd_data_valid = 1'b0; #1;
    check("ld_done_rdv", o_rd_valid, 1);
    check("ld_done_data", o_rd_data, 32'h1234_5678);
    check("ld_done_stall", o_stall, 0);
    check("ld_done_err", o_err, 0);
    step();
    i_req_valid = 1'b0;
    i_app_rd_data = 32'h5555_AAAA; i_app_rd_data_valid = 1'b1; #1;
    check("ld_idle_rdv", o_rd_valid, 0);
    step(); #1;
    check("ld_stray_hold", o_rd_data, 32'h1234_5678);
    check("ld_stray_stall", o_stall, 0);
    i_app_rd_data_valid = 1'b0;

    // Load that times out after 255 wait cycles
    step();
    req(1'b0, 32'h0000_0300, 32'h0, 4'b0000);
    i_app_rdy = 1'b1;
    step();
    step();
    i_app_rdy = 1'b0;
    for (int i = 1; i < 255; i++) step();
    #1;
    check("to_last_stall", o_stall, 1);
    check("to_last_err", o_err, 0);
    step(); #1;
    check("to_done_err", o_err, 1);
    check("to_done_rdv", o_rd_valid, 1);
    check("to_done_data", o_rd_data, 32'hDEAD_BEEF);
    check("to_done_stall", o_stall, 0);
    step();
    i_req_valid = 1'b0; #1;
    check("to_idle_err", o_err, 0);
    check("to_idle_stall", o_stall, 0);

    // Data in the final wait cycle wins over the timeout
    step();
    req(1'b0, 32'h0000_0400, 32'h0, 4'b0000);
    i_app_rdy = 1'b1;
    step();
    step();
    i_app_rdy = 1'b0;
    for (int i = 1; i < 255; i++) step();
    i_app_rd_data = 32'hCAFE_F00D; i_app_rd_data_valid = 1'b1;
    step();
    i_app_rd_data_valid = 1'b0; #1;
    check("pri_err", o_err, 0);
    check("pri_rdv", o_rd_valid, 1);
    check("pri_data", o_rd_data, 32'hCAFE_F00D);
    step();
    i_req_valid = 1'b0;

    // Reset while waiting for read data, then stray data
    step();
    req(1'b0, 32'h0000_0500, 32'h0, 4'b0000);
    i_app_rdy = 1'b1;
    step();
    step();
    i_app_rdy = 1'b0;
    step();
    i_req_valid = 1'b0; i_reset_n = 1'b0;
    step(); #1;
    check("rw_rst_stall", o_stall, 0);
    check("rw_rst_data", o_rd_data, 0);
    i_reset_n = 1'b1;
    i_app_rd_data = 32'h7777_7777; i_app_rd_data_valid = 1'b1;
    step(); #1;
    check("rw_after_en", o_app_en, 0);
    check("rw_after_wren", o_app_wdf_wren, 0);
    check("rw_after_stall", o_stall, 0);
    check("rw_after_data", o_rd_data, 0);
    check("rw_after_rdv", o_rd_valid, 0);
    i_app_rd_data_valid = 1'b0;

    // Back-to-back store then load
    step();
    cmd_base = n_cmd;
    req(1'b1, 32'h0000_0600, 32'h1111_2222, 4'b1000);
    i_app_rdy = 1'b1; i_app_wdf_rdy = 1'b1;
    step(); #1;
    check("bb_wr_en", o_app_en, 1);
    step(); #1;
    check("bb_wr_done_stall", o_stall, 0);
    check("bb_wr_done_en", o_app_en, 0);
    step();
    req(1'b0, 32'h0000_0704, 32'h0, 4'b0000); #1;
    check("bb_ld_idle_stall", o_stall, 1);
    check("bb_ld_idle_en", o_app_en, 0);
    step(); #1;
    check("bb_ld_cmd", o_app_cmd, 3'b001);
    check("bb_ld_addr", o_app_addr, 28'h704);
    step();
    i_app_rd_data = 32'h0F0F_0F0F; i_app_rd_data_valid = 1'b1;
    step();
    i_app_rd_data_valid = 1'b0; #1;
    check("bb_ld_rdv", o_rd_valid, 1);
    check("bb_ld_data", o_rd_data, 32'h0F0F_0F0F);
    step();
    i_req_valid = 1'b0; #1;
    check("bb_idle_stall", o_stall, 0);
    step();
    step(); #1;
    check("bb_cmd_count", n_cmd - cmd_base, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
